tx_buffer_arbiter: RTL and testbench
====================================

// Module: tx_buffer_arbiter
// PURPOSE
//  Sequential, parametrised successor of the combinational tx buffer selecter.
//  Arbitrates NUM_CH per-channel tx flit buffers onto the single transmitter.
//  Round-robin grant at packet boundaries; grant locked until last flit accepted.
//  Sits between per-channel tx FIFOs and the flit transmitter/serialiser.
// PARAMETERS
//  NUM_CH   4   number of tx buffer channels (>=1)
//  FLIT_W   64  flit width in bits
//  CH_W     (NUM_CH>1 ? $clog2(NUM_CH) : 1)  channel index width (derived, localparam)
// PORTS
//  clk        in   1             system clock, rising edge
//  rst_n      in   1             asynchronous, active-low reset
//  in_valid   in   NUM_CH        per-channel flit valid
//  in_data    in   NUM_CH*FLIT_W per-channel flit; ch i at [i*FLIT_W +: FLIT_W]
//  in_last    in   NUM_CH        per-channel last flit of packet
//  in_ready   out  NUM_CH        per-channel flit accepted when valid&ready
//  out_valid  out  1             flit to transmitter valid
//  out_data   out  FLIT_W        flit to transmitter
//  out_last   out  1             last flit of current packet
//  out_ch     out  CH_W          channel index of current grant
//  out_ready  in   1             transmitter accepts flit
//  busy       out  1             1 while in LOCK
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, grant=0, rr_ptr=NUM_CH-1 (ch0 wins first);
//   in_ready=0, out_valid=0, out_last=0, out_data=0, out_ch=0, busy=0.
//  States: IDLE, LOCK (registered).
//  IDLE: in_ready=0, out_valid=0. On clk edge with |in_valid: grant <= first
//   requester searching rr_ptr+1, rr_ptr+2, ... modulo NUM_CH; state <= LOCK.
//   No requester: stay IDLE. Arbitration costs exactly one bubble cycle.
//  LOCK: out_valid=in_valid[grant], out_data=in_data[grant], out_last=in_last[grant],
//   out_ch=grant, in_ready[grant]=out_ready, in_ready[other]=0 (comb pass-through,
//   zero latency). Transfer = out_valid & out_ready.
//  LOCK exit: transfer & out_last -> state <= IDLE, rr_ptr <= grant.
//  Granted channel valid drops mid-packet: out_valid=0, stay LOCK, no re-arbitration.
//  Single-flit packet: valid&last accepted in first LOCK cycle -> IDLE next cycle.
//  Same channel re-granted back-to-back only if no other channel requests.
//  out_ready low: hold; data must not change (source responsibility, valid/ready).
//  Non-granted requests are never dropped; their in_ready stays 0.
//  out_data/out_last in IDLE driven 0 (no X leakage to transmitter).
//  Reset asserted mid-packet: immediate IDLE, all outputs to reset values;
//   partial packet is abandoned (upstream flushes on its own reset).
//  rr_ptr modulo wrap: rr_ptr=NUM_CH-1 -> search starts at ch0. NUM_CH=1: grant always 0.
// CONFIGURATION
//  TX_ARB_PRIO_CH0_EN defined: in IDLE, in_valid[0]=1 wins over round-robin
//   (control/ack packets); rr_ptr not updated on ch0 grants; other channels
//   round-robin among themselves. Lock semantics unchanged (no preemption).
//  Undefined: pure round-robin over all channels, ch0 treated like any other.
// TESTING
//  Reset: rst_n=0 with in_valid=4'hF -> all outputs 0, busy=0, in_ready=0.
//  Single request: ch2 valid, 3 flits (last on 3rd), out_ready=1 -> 1 bubble,
//   then out_ch=2, 3 transfers, out_data matches, busy falls after 3rd flit.
//  Fairness: in_valid=4'hF, 1-flit packets, continuous -> grant order 0,1,2,3,0.
//  Stall: out_ready=0 for 5 cycles mid-packet on ch1 -> in_ready[1]=0, out_data
//   stable, no grant change; resume -> remaining flits delivered, order intact.
//  Valid gap + reset: ch3 drops valid mid-packet -> out_valid=0, out_ch=3 held;
//   assert rst_n=0 -> state IDLE, outputs 0 asynchronously.
//  TX_ARB_PRIO_CH0_EN: ch1 locked, ch0 & ch2 request -> ch1 completes, then ch0,
//   then ch2; with macro undefined -> ch2 then ch0.

Source files
------------

// File: rtl/tx_buffer_arbiter.sv
// Round-robin arbiter of NUM_CH tx flit buffers onto one transmitter.
// Optional macro TX_ARB_PRIO_CH0_EN: ch0 wins every idle arbitration.
module tx_buffer_arbiter #(
  parameter int NUM_CH = 4,
  parameter int FLIT_W = 64,
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_CH-1:0]        in_valid,
  input  logic [NUM_CH*FLIT_W-1:0] in_data,
  input  logic [NUM_CH-1:0]        in_last,
  output logic [NUM_CH-1:0]        in_ready,
  output logic                     out_valid,
  output logic [FLIT_W-1:0]        out_data,
  output logic                     out_last,
  output logic [CH_W-1:0]          out_ch,
  input  logic                     out_ready,
  output logic                     busy
);

  typedef enum logic {
    IDLE,
    LOCK
  } state_t;

  state_t          state_q, state_d;
  logic [CH_W-1:0] grant_q, grant_d;
  logic [CH_W-1:0] rr_q, rr_d;
  logic [CH_W-1:0] pick;
  logic            found;
  int              idx;

  // First requester after rr_q, wrapping modulo NUM_CH
  always_comb begin
    pick  = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 1; k <= NUM_CH; k++) begin
      idx = (int'(rr_q) + k) % NUM_CH;
      if (!found && in_valid[idx]) begin
        found = 1'b1;
        pick  = CH_W'(idx);
      end
    end
`ifdef TX_ARB_PRIO_CH0_EN
    if (in_valid[0]) begin
      pick = '0;
    end
`endif
  end

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    rr_d      = rr_q;
    in_ready  = '0;
    out_valid = 1'b0;
    out_data  = '0;
    out_last  = 1'b0;
    out_ch    = '0;
    busy      = 1'b0;
    case (state_q)
      IDLE: begin
        if (|in_valid) begin
          grant_d = pick;
          state_d = LOCK;
        end
      end
      LOCK: begin
        busy      = 1'b1;
        out_ch    = grant_q;
        out_valid = in_valid[grant_q];
        out_last  = in_last[grant_q];
        out_data  = in_data[grant_q*FLIT_W +: FLIT_W];
        in_ready[grant_q] = out_ready;
        if (out_valid && out_ready && out_last) begin
          state_d = IDLE;
`ifdef TX_ARB_PRIO_CH0_EN
          // ch0 grants leave the rotation untouched
          if (grant_q != '0) begin
            rr_d = grant_q;
          end
`else
          rr_d = grant_q;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      rr_q    <= CH_W'(NUM_CH - 1);
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      rr_q    <= rr_d;
    end
  end

endmodule

// File: tb/tb_tx_buffer_arbiter.sv
// Bench for tx_buffer_arbiter: packet-level model plus directed packets.
// Honours TX_ARB_PRIO_CH0_EN in both the model and the expected orders.
module tb_tx_buffer_arbiter;

`ifdef TX_ARB_PRIO_CH0_EN
  localparam bit PRIO = 1'b1;
`else
  localparam bit PRIO = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [3:0]   in_valid = '0;
  logic [255:0] in_data = '0;
  logic [3:0]   in_last = '0;
  logic [3:0]   in_ready;
  logic         out_valid;
  logic [63:0]  out_data;
  logic         out_last;
  logic [1:0]   out_ch;
  logic         out_ready = 1'b1;
  logic         busy;

  tx_buffer_arbiter #(.NUM_CH(4), .FLIT_W(64)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_data(in_data),
    .in_last(in_last), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data),
    .out_last(out_last), .out_ch(out_ch),
    .out_ready(out_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;

  // Per-channel packet sources: {last, data}
  logic [64:0] mem [4][16];
  int          hd [4];
  int          tl [4];
  logic [3:0]  en = 4'hF;

  int          log_ch [$];
  logic [63:0] log_d [$];
  int          log_c [$];

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < 4; i++) begin
      if (hd[i] < tl[i]) begin
        in_valid[i] = en[i];
        in_data[i*64 +: 64] = mem[i][hd[i]][63:0];
        in_last[i] = mem[i][hd[i]][64];
      end else begin
        in_valid[i] = 1'b0;
        in_data[i*64 +: 64] = '0;
        in_last[i] = 1'b0;
      end
    end
  endtask

  task automatic push(int ch, logic [63:0] d, logic l);
    mem[ch][tl[ch]] = {l, d};
    tl[ch]++;
  endtask

  task automatic step();
    logic [3:0] f;
    @(negedge clk);
    f = in_valid & in_ready;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++)
      if (f[i]) hd[i]++;
    drive();
  endtask

  task automatic wait_log(int n);
    int b;
    b = 0;
    while (log_ch.size() < n && b < 300) begin
      step();
      b++;
    end
    n_cmp++;
    if (log_ch.size() < n) begin
      n_err++;
      $display("FAIL timeout: got %0d flits want %0d",
               log_ch.size(), n);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    out_ready = 1'b1;
    en = 4'hF;
    for (int i = 0; i < 4; i++) begin
      hd[i] = 0;
      tl[i] = 0;
    end
    drive();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    log_ch.delete();
    log_d.delete();
    log_c.delete();
  endtask

  // Packet-level model: which channel owns the link, last served channel
  bit m_lock;
  int m_ch;
  int m_last;

  function automatic int winner(logic [3:0] req, int last);
    if (PRIO && req[0]) return 0;
    for (int k = 1; k <= 4; k++)
      if (req[(last + k) % 4]) return (last + k) % 4;
    return 0;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_lock <= 1'b0;
      m_ch   <= 0;
      m_last <= 3;
    end else if (!m_lock) begin
      if (|in_valid) begin
        m_lock <= 1'b1;
        m_ch   <= winner(in_valid, m_last);
      end
    end else if (in_valid[m_ch] && out_ready && in_last[m_ch]) begin
      m_lock <= 1'b0;
      if (!(PRIO && m_ch == 0)) m_last <= m_ch;
    end
  end

  always @(negedge clk) begin
    logic        e_v, e_l, e_b;
    logic [63:0] e_d;
    logic [3:0]  e_r;
    cyc++;
    if (rst_n) begin
      e_b = m_lock;
      e_v = m_lock ? in_valid[m_ch] : 1'b0;
      e_l = m_lock ? in_last[m_ch] : 1'b0;
      e_d = m_lock ? in_data[m_ch*64 +: 64] : 64'h0;
      e_r = (m_lock && out_ready) ? (4'b1 << m_ch) : 4'b0;
      n_cmp++;
      if (out_valid !== e_v || out_last !== e_l || out_data !== e_d ||
          in_ready !== e_r || busy !== e_b ||
          (m_lock && out_ch !== 2'(m_ch))) begin
        n_err++;
        $display("FAIL model cyc%0d: got v%b l%b d%h r%b b%b ch%0d want v%b l%b d%h r%b b%b ch%0d",
                 cyc, out_valid, out_last, out_data, in_ready, busy, out_ch,
                 e_v, e_l, e_d, e_r, e_b, m_ch);
      end
      if (out_valid && out_ready) begin
        log_ch.push_back(int'(out_ch));
        log_d.push_back(out_data);
        log_c.push_back(cyc);
      end
    end
  end

  initial begin
    int start;
    int ord [8];
    for (int i = 0; i < 4; i++) begin
      hd[i] = 0;
      tl[i] = 0;
    end

    // Reset with every channel requesting
    rst_n = 1'b0;
    in_valid = 4'hF;
    in_data = {256{1'b1}};
    in_last = 4'hF;
    #1;
    chk("rst_valid", {63'h0, out_valid}, 64'h0);
    chk("rst_data", out_data, 64'h0);
    chk("rst_ready", {60'h0, in_ready}, 64'h0);
    chk("rst_busy", {63'h0, busy}, 64'h0);
    @(posedge clk);
    #1;
    chk("rst_edge", {out_ch, out_last, busy, out_valid}, 64'h0);

    // Single 3-flit packet on ch2
    do_reset();
    push(2, 64'h2000_0000_0000_0001, 1'b0);
    push(2, 64'h2000_0000_0000_0002, 1'b0);
    push(2, 64'h2000_0000_0000_0003, 1'b1);
    drive();
    start = cyc;
    wait_log(3);
    step();
    chk("single_ch", 64'(log_ch[0]), 64'd2);
    chk("single_d0", log_d[0], 64'h2000_0000_0000_0001);
    chk("single_d2", log_d[2], 64'h2000_0000_0000_0003);
    chk("single_bubble", 64'(log_c[0] - start), 64'd2);
    chk("single_b2b", 64'(log_c[2] - log_c[0]), 64'd2);
    chk("single_busy", {63'h0, busy}, 64'h0);

    // Fairness with single-flit packets on all channels
    do_reset();
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < 4; i++)
        push(i, 64'hA0 + 64'(r * 16 + i), 1'b1);
    drive();
    wait_log(8);
    if (PRIO) ord = '{0, 0, 1, 2, 3, 1, 2, 3};
    else      ord = '{0, 1, 2, 3, 0, 1, 2, 3};
    for (int i = 0; i < 8; i++)
      chk($sformatf("fair_%0d", i), 64'(log_ch[i]), 64'(ord[i]));

    // Stall on ch1 mid-packet
    do_reset();
    for (int k = 1; k <= 4; k++)
      push(1, 64'h1111_0000_0000_0000 + 64'(k), k == 4);
    drive();
    wait_log(2);
    out_ready = 1'b0;
    for (int s = 0; s < 5; s++) begin
      step();
      chk("stall_ready", {60'h0, in_ready}, 64'h0);
      chk("stall_data", out_data, 64'h1111_0000_0000_0003);
      chk("stall_ch", {62'h0, out_ch}, 64'd1);
    end
    chk("stall_cnt", 64'(log_ch.size()), 64'd2);
    out_ready = 1'b1;
    wait_log(4);
    chk("stall_d2", log_d[2], 64'h1111_0000_0000_0003);
    chk("stall_d3", log_d[3], 64'h1111_0000_0000_0004);

    // Valid gap on ch3, then asynchronous reset mid-packet
    do_reset();
    for (int k = 1; k <= 3; k++)
      push(3, 64'h3333_0000_0000_0000 + 64'(k), k == 3);
    drive();
    wait_log(1);
    en[3] = 1'b0;
    drive();
    repeat (3) step();
    chk("gap_valid", {63'h0, out_valid}, 64'h0);
    chk("gap_ch", {62'h0, out_ch}, 64'd3);
    chk("gap_busy", {63'h0, busy}, 64'h1);
    en[3] = 1'b1;
    drive();
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_busy", {63'h0, busy}, 64'h0);
    chk("arst_out", {out_ch, out_last, out_valid}, 64'h0);
    chk("arst_data", out_data, 64'h0);
    chk("arst_ready", {60'h0, in_ready}, 64'h0);

    // ch1 locked while ch0 and ch2 start requesting
    do_reset();
    for (int k = 1; k <= 3; k++)
      push(1, 64'h0101_0000_0000_0000 + 64'(k), k == 3);
    drive();
    wait_log(1);
    push(0, 64'h0000_0000_0000_00C0, 1'b1);
    push(2, 64'h0202_0000_0000_00C2, 1'b1);
    drive();
    wait_log(5);
    chk("prio_l2", 64'(log_ch[2]), 64'd1);
    chk("prio_a", 64'(log_ch[3]), PRIO ? 64'd0 : 64'd2);
    chk("prio_b", 64'(log_ch[4]), PRIO ? 64'd2 : 64'd0);

    repeat (3) step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
